multi_clk_div: RTL and testbench
================================

// Module: multi_clk_div
// PURPOSE
//   Parametrised clock-divider bank with an LED pattern sequencer; next generation of the 3-bit div/LED blinker.
//   CH independent channels, each a 50%-duty divided clock with a runtime half-period.
//   Sits between the board clock and the LED bank; outputs are clk-domain registers, never used as clocks.
// PARAMETERS
//   CH     3   number of divider channels; also the LED count (>=1)
//   CNT_W  16  half-period counter width per channel
// PORTS
//   clk       in   1         system clock; all logic on posedge
//   reset     in   1         synchronous, active-high reset
//   en        in   1         1 = counters run; 0 = freeze all state
//   mode      in   2         LED pattern: 0 BIN, 1 ROT, 2 BOUNCE, 3 HOLD
//   div_half  in   CH*CNT_W  channel i half-period in clk cycles, bits [i*CNT_W +: CNT_W]
//   clk_div   out  CH        divided square waves, period 2*H_i
//   led       out  CH        LED pattern
//   tick      out  CH        only with MULTI_CLK_DIV_TICK_EN; see CONFIGURATION
// BEHAVIOUR
//   Reset (reset=1 at posedge): cnt_i=0, clk_div=0, led=0, dir=UP, tick=0, shadow H_i<=max(div_half_i,1).
//   Channel i, per cycle with en=1: if cnt_i==H_i-1 -> cnt_i<=0, clk_div[i] toggles, H_i reloads from div_half_i
//     (0 treated as 1); else cnt_i<=cnt_i+1. First toggle H_i cycles after reset release.
//   div_half changes take effect only at the wrap; the current half-period always completes at the old value.
//   en=0: counters, clk_div, led, dir all hold; resuming continues the same phase, no skipped or extra toggle.
//   Step event: the cycle in which clk_div[CH-1] goes 0->1 (wrap with clk_div[CH-1]==0). The LED updates on a
//     step only, registered in the same cycle as the toggle. Mode is sampled at the step.
//   BIN: led <= led+1 mod 2^CH.
//   ROT: if led not one-hot, led<=1; else rotate left, MSB wraps to bit 0.
//   BOUNCE: two-state FSM UP/DOWN. If led not one-hot, led<=1 and dir<=UP. UP: shift left; on reaching bit CH-1,
//     dir<=DOWN. DOWN: shift right; on reaching bit 0, dir<=UP. Ends are visited once per sweep. CH==1: led stays 1.
//   HOLD: led and dir unchanged.
//   Mode change mid-run: no immediate effect; applies at the next step.
//   Reset mid-operation overrides en and all events; the next cycle shows the reset values.
// CONFIGURATION
//   MULTI_CLK_DIV_TICK_EN defined: adds output tick[CH-1:0]. tick[i]=1 for exactly the cycle after each channel-i wrap
//     (both edges), registered; 0 in reset and while en=0.
//   Undefined: no tick port; all other behaviour identical.
// STRUCTURE
//   Package multi_clk_div_pkg: MODE_BIN/ROT/BOUNCE/HOLD 2-bit localparams; DIR_UP/DIR_DOWN encoding.
//   Sub-module div_chan (cnt, shadow H, toggle, wrap strobe; CNT_W param), generated CH times.
//   The LED sequencer and BOUNCE FSM live in the top level.
// TESTING (CH=3, CNT_W=8)
//   Set div_half={8'd4,8'd2,8'd1}, en=1 after reset -> clk_div[0] toggles every cycle, [1] every 2, [2] every 4;
//     first toggles 1/2/4 cycles after release.
//   mode=0 -> led 0,1,2,...,7,0 with one increment per clk_div[2] rising edge (every 8 cycles).
//   mode=1 from led=3'b101 -> 001,010,100,001 on successive steps.
//   mode=2 -> 001,010,100,010,001,010. Switch to mode=3 mid-sweep -> led frozen; back to 2 -> sweep resumes
//     the saved direction.
//   en=0 for 5 cycles mid-period -> all outputs constant; then en=1 -> the next toggle arrives after the remaining
//     count. Change div_half[0] 1->3 mid-run -> the current period completes, then a 6-cycle period.
//   Assert reset mid-sweep with en=1 -> next cycle clk_div=0, led=0, tick=0. With the macro, tick[1] pulses every
//     2 cycles under the first stimulus.

Source files
------------

// File: rtl/multi_clk_div_pkg.sv
// Shared encodings for the clock-divider bank: LED pattern modes and the BOUNCE sweep direction.
package multi_clk_div_pkg;
  localparam logic [1:0] MODE_BIN    = 2'd0;
  localparam logic [1:0] MODE_ROT    = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
endpackage

// File: rtl/div_chan.sv
// One divider channel: half-period counter, shadowed half-period, toggling output and wrap strobe.
module div_chan #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] div_half,
  output logic             clk_div,
  output logic             wrap
);
  logic [CNT_W-1:0] cnt_q, h_q, h_ld;

  // A zero half-period would never wrap; treat it as one cycle.
  assign h_ld = (div_half == '0) ? CNT_W'(1) : div_half;
  assign wrap = en && (cnt_q == h_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      h_q     <= h_ld;
      clk_div <= 1'b0;
    end else if (wrap) begin
      cnt_q   <= '0;
      h_q     <= h_ld;
      clk_div <= ~clk_div;
    end else if (en) begin
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/multi_clk_div.sv
// CH-channel clock-divider bank with an LED pattern sequencer stepped by clk_div[CH-1] rising.
// Define MULTI_CLK_DIV_TICK_EN to add the registered per-channel wrap pulse output tick.
module multi_clk_div
  import multi_clk_div_pkg::*;
#(
  parameter int CH    = 3,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [CH*CNT_W-1:0] div_half,
  output logic [CH-1:0]       clk_div,
  output logic [CH-1:0]       led
`ifdef MULTI_CLK_DIV_TICK_EN
  ,
  output logic [CH-1:0]       tick
`endif
);
  localparam logic [CH-1:0] LED0 = CH'(1);

  logic [CH-1:0][CNT_W-1:0] half;
  logic [CH-1:0]            wrap;

  assign half = div_half;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    div_chan #(.CNT_W(CNT_W)) u_chan (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .div_half (half[i]),
      .clk_div  (clk_div[i]),
      .wrap     (wrap[i])
    );
  end

  logic          step, led_onehot;
  logic [CH-1:0] led_d;
  dir_e          dir_q, dir_d;

  // Wrap while the slowest output is low is exactly its 0->1 edge.
  assign step       = wrap[CH-1] & ~clk_div[CH-1];
  assign led_onehot = (led != '0) && ((led & (led - 1'b1)) == '0);

  always_comb begin
    logic go_up;
    led_d = led;
    dir_d = dir_q;
    go_up = 1'b0;
    if (step) begin
      case (mode)
        MODE_BIN: led_d = led + 1'b1;
        MODE_ROT: led_d = led_onehot ? ((led << 1) | (led >> (CH - 1))) : LED0;
        MODE_BOUNCE: begin
          if (!led_onehot) begin
            led_d = LED0;
            dir_d = DIR_UP;
          end else if (CH == 1) begin
            led_d = LED0;
          end else begin
            // Bounce off either end even if the saved direction points past it.
            go_up = led[0] | ((dir_q == DIR_UP) & ~led[CH-1]);
            if (go_up) begin
              led_d = led << 1;
              dir_d = led_d[CH-1] ? DIR_DOWN : DIR_UP;
            end else begin
              led_d = led >> 1;
              dir_d = led_d[0] ? DIR_UP : DIR_DOWN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led   <= '0;
      dir_q <= DIR_UP;
    end else begin
      led   <= led_d;
      dir_q <= dir_d;
    end
  end

`ifdef MULTI_CLK_DIV_TICK_EN
  always_ff @(posedge clk) begin
    if (reset) tick <= '0;
    else       tick <= wrap;
  end
`endif
endmodule

// File: tb/tb_multi_clk_div.sv
// Scoreboarded bench for multi_clk_div (CH=3, CNT_W=8) with directed LED-sequence checks.
module tb_multi_clk_div;
  localparam int CH    = 3;
  localparam int CNT_W = 8;

  logic                clk = 1'b0;
  logic                reset, en;
  logic [1:0]          mode;
  logic [CH*CNT_W-1:0] div_half;
  logic [CH-1:0]       clk_div, led;
`ifdef MULTI_CLK_DIV_TICK_EN
  logic [CH-1:0]       tick;
`endif

  multi_clk_div #(.CH(CH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .div_half (div_half),
    .clk_div  (clk_div),
`ifdef MULTI_CLK_DIV_TICK_EN
    .tick     (tick),
`endif
    .led      (led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] cd;
    logic [CH-1:0] led;
    logic [CH-1:0] tk;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: count-down timers per channel, spec-literal LED rules.
  logic [CH-1:0] m_cd, m_led, m_tk;
  logic          m_up, m_step;
  int            m_left[CH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int hv(input int i);
    int v;
    v = int'(div_half[i*CNT_W +: CNT_W]);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_edge();
    m_step = 1'b0;
    if (reset) begin
      m_cd = '0; m_led = '0; m_tk = '0; m_up = 1'b1;
      for (int i = 0; i < CH; i++) m_left[i] = hv(i);
      return;
    end
    m_tk = '0;
    if (!en) return;
    for (int i = 0; i < CH; i++) begin
      m_left[i]--;
      if (m_left[i] == 0) begin
        if (i == CH - 1 && !m_cd[i]) m_step = 1'b1;
        m_cd[i]   = ~m_cd[i];
        m_tk[i]   = 1'b1;
        m_left[i] = hv(i);
      end
    end
    if (m_step) begin
      case (mode)
        2'd0: m_led = m_led + 3'd1;
        2'd1: m_led = $onehot(m_led) ? {m_led[1:0], m_led[2]} : 3'b001;
        2'd2: begin
          if (!$onehot(m_led)) begin
            m_led = 3'b001; m_up = 1'b1;
          end else if (m_up) begin
            m_led = m_led << 1;
            if (m_led == 3'b100) m_up = 1'b0;
          end else begin
            m_led = m_led >> 1;
            if (m_led == 3'b001) m_up = 1'b1;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input int n = 1);
    exp_t e;
    repeat (n) begin
      model_edge();
      sb_q.push_back('{m_cd, m_led, m_tk});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk("sb_clk_div", 32'(clk_div), 32'(e.cd));
      chk("sb_led", 32'(led), 32'(e.led));
`ifdef MULTI_CLK_DIV_TICK_EN
      chk("sb_tick", 32'(tick), 32'(e.tk));
`endif
    end
  endtask

  task automatic run_to_step();
    int k;
    k = 0;
    do begin
      cyc();
      k++;
    end while (!m_step && k < 64);
    if (!m_step) chk("step_timeout", 32'd0, 32'd1);
  endtask

  logic [CH-1:0] hold_cd, hold_led;

  initial begin
    reset = 1'b1; en = 1'b0; mode = 2'd0;
    div_half = {8'd4, 8'd2, 8'd1};
    cyc(2);
    chk("rst_clk_div", 32'(clk_div), 32'd0);
    chk("rst_led", 32'(led), 32'd0);

    reset = 1'b0; en = 1'b1;
    cyc(1); chk("first_tog0", 32'(clk_div), 32'b001);
    cyc(1); chk("first_tog1", 32'(clk_div), 32'b010);
    cyc(2); chk("first_tog2", 32'(clk_div), 32'b100);
    chk("bin_1", 32'(led), 32'd1);
    for (int k = 2; k <= 13; k++) begin
      run_to_step();
      chk("bin_step", 32'(led), 32'(k % 8));
    end

    mode = 2'd1;
    run_to_step(); chk("rot_0", 32'(led), 32'b001);
    run_to_step(); chk("rot_1", 32'(led), 32'b010);
    run_to_step(); chk("rot_2", 32'(led), 32'b100);
    run_to_step(); chk("rot_3", 32'(led), 32'b001);

    mode = 2'd2;
    run_to_step(); chk("bnc_0", 32'(led), 32'b010);
    run_to_step(); chk("bnc_1", 32'(led), 32'b100);
    run_to_step(); chk("bnc_2", 32'(led), 32'b010);
    run_to_step(); chk("bnc_3", 32'(led), 32'b001);
    run_to_step(); chk("bnc_4", 32'(led), 32'b010);

    mode = 2'd3;
    run_to_step(); chk("hold_0", 32'(led), 32'b010);
    run_to_step(); chk("hold_1", 32'(led), 32'b010);
    mode = 2'd2;
    run_to_step(); chk("resume_0", 32'(led), 32'b100);
    run_to_step(); chk("resume_1", 32'(led), 32'b010);

    cyc(3);
    hold_cd = clk_div; hold_led = led;
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk("pause_clk_div", 32'(clk_div), 32'(hold_cd));
      chk("pause_led", 32'(led), 32'(hold_led));
    end
    en = 1'b1;
    cyc(16);

    div_half[7:0] = 8'd3;
    cyc(24);

    reset = 1'b1;
    cyc(1);
    chk("rst_mid_clk_div", 32'(clk_div), 32'd0);
    chk("rst_mid_led", 32'(led), 32'd0);
`ifdef MULTI_CLK_DIV_TICK_EN
    chk("rst_mid_tick", 32'(tick), 32'd0);
`endif
    reset = 1'b0;
    cyc(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
